// File: rtl/pclk_rate_ctrl.sv
// Rate-select sequencer for the glitch-free PIPE clock mux: quiesces pclk users,
// switches the mux rate, waits for its acknowledge, lets the clock settle, then re-enables.
module pclk_rate_ctrl #(
    parameter int QUIESCE_CYCLES = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [1:0] req_rate,
    output logic       req_ready,
    input  logic       switch_ack,
    output logic [1:0] rate,
    output logic       pclk_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        QUIESCE,
        WAIT_ACK,
        SETTLE
    } state_t;

    localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ack_q;
    logic             ack_rise;
    logic             fail;
    logic [1:0]       target;
    logic [1:0]       old_rate;

    assign ack_rise = switch_ack & ~ack_q;
    assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ack_q     <= 1'b0;
            fail      <= 1'b0;
            target    <= '0;
            old_rate  <= '0;
            rate      <= '0;
            pclk_en   <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack_q <= switch_ack;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_rate == 2'b11) begin
                            err <= 1'b1;
                        end else if (req_rate == rate) begin
                            done <= 1'b1;
                        end else begin
                            target    <= req_rate;
                            old_rate  <= rate;
                            pclk_en   <= 1'b0;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                            cnt       <= '0;
                            state     <= QUIESCE;
                        end
                    end
                end
                QUIESCE: begin
                    if (cnt == QUIESCE_LAST) begin
                        rate  <= target;
                        cnt   <= '0;
                        state <= WAIT_ACK;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                WAIT_ACK: begin
                    // An ack edge on the timeout cycle still counts as success.
                    if (ack_rise) begin
                        fail  <= 1'b0;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        rate  <= old_rate;
                        err   <= 1'b1;
                        fail  <= 1'b1;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        pclk_en   <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        done      <= ~fail;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
